// File: rtl/axi_seg_2_axis_simple_if.sv
// Bus interfaces for axi_seg_2_axis_simple.
//   axi_seg_2_axis_simple_seg_if  : 8x128-bit segmented stream from the MAC (ena/sop/eop/err/mty).
//   axi_seg_2_axis_simple_axis_if : flat AXI-Stream toward the RoCE RX stack.
interface axi_seg_2_axis_simple_seg_if #(
    parameter int SEG_COUNT      = 8,
    parameter int SEG_DATA_WIDTH = 128
);
    localparam int MTY_W = $clog2(SEG_DATA_WIDTH / 8);

    logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] tdata;
    logic                                tvalid;
    logic                                tready;
    logic [SEG_COUNT-1:0]                tuser_ena;
    logic [SEG_COUNT-1:0]                tuser_sop;
    logic [SEG_COUNT-1:0]                tuser_eop;
    logic [SEG_COUNT-1:0]                tuser_err;
    logic [SEG_COUNT*MTY_W-1:0]          tuser_mty;

    modport master (
        output tdata, tvalid, tuser_ena, tuser_sop, tuser_eop, tuser_err, tuser_mty,
        input  tready
    );
    modport slave (
        input  tdata, tvalid, tuser_ena, tuser_sop, tuser_eop, tuser_err, tuser_mty,
        output tready
    );
endinterface

interface axi_seg_2_axis_simple_axis_if #(
    parameter int DATA_WIDTH = 1024
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic                    tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input  tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axi_seg_2_axis_simple.sv
// Segmented (8 x 128-bit) RX stream to 1024-bit AXI-Stream converter.
// Packets are segment-0 aligned; malformed framing is truncated or dropped and flagged
// via tuser. Output is a two-register skid buffer giving full throughput.
// Optional statistics counters are built when AXIS_SEG_STATS_EN is defined; otherwise
// the stat_* ports read as zero.
module axi_seg_2_axis_simple #(
    parameter int SEG_COUNT      = 8,
    parameter int SEG_DATA_WIDTH = 128,
    parameter int COUNTER_WIDTH  = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    axi_seg_2_axis_simple_seg_if.slave          s_axis_seg,
    axi_seg_2_axis_simple_axis_if.master        m_axis,
    output logic [COUNTER_WIDTH-1:0]            stat_pkt_count,
    output logic [COUNTER_WIDTH-1:0]            stat_err_count,
    output logic [COUNTER_WIDTH-1:0]            stat_drop_count
);
    localparam int KEEP_W  = SEG_DATA_WIDTH / 8;
    localparam int MTY_W   = $clog2(KEEP_W);
    localparam int DATA_W  = SEG_COUNT * SEG_DATA_WIDTH;
    localparam int TKEEP_W = SEG_COUNT * KEEP_W;

    localparam logic [SEG_COUNT-1:0] SEG_ONE   = SEG_COUNT'(1);
    localparam logic [KEEP_W-1:0]    KEEP_ONES = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_IN_PKT, ST_DROP} state_t;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [TKEEP_W-1:0] keep;
        logic               last;
        logic               user;
    } beat_t;

    state_t               state_q, state_d;
    logic [SEG_COUNT-1:0] ena, sop, eop, ena_top;
    logic [TKEEP_W-1:0]   beat_keep;
    logic                 beat_last, beat_err, viol;
    logic                 beat_accept, beat_emit, emit_last, emit_user;
    beat_t                in_beat, out_q, tmp_q;
    logic                 out_valid_q, out_valid_d, tmp_valid_q, tmp_valid_d;
    logic                 s_tready_q, s_tready_d;
    logic                 load_out_from_in, load_tmp_from_in, load_out_from_tmp;

    // Beat decode: per-segment byte enables, end-of-packet, MAC error and framing checks.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        ena       = s_axis_seg.tuser_ena;
        sop       = s_axis_seg.tuser_sop;
        eop       = s_axis_seg.tuser_eop;
        beat_keep = '0;
        for (int i = 0; i < SEG_COUNT; i++) begin
            if (ena[i]) begin
                if (eop[i]) beat_keep[i*KEEP_W +: KEEP_W] = KEEP_ONES >> s_axis_seg.tuser_mty[i*MTY_W +: MTY_W];
                else        beat_keep[i*KEEP_W +: KEEP_W] = KEEP_ONES;
            end
        end
        ena_top   = ena & ~(ena >> 1);
        beat_last = |(eop & ena);
        beat_err  = |(s_axis_seg.tuser_err & eop & ena);
        viol      = ((ena & (ena + SEG_ONE)) != '0)              // enables not a prefix from segment 0
                  | (sop[SEG_COUNT-1:1] != '0)                   // sop outside segment 0
                  | ((eop & (eop - SEG_ONE)) != '0)              // more than one eop
                  | ((eop != '0) && (eop != ena_top))            // eop not in top enabled segment
                  | (!beat_last && (ena != '1));                 // short beat without eop
    end

    // A beat is consumed when handshaken; all-disabled beats are swallowed without effect.
    assign beat_accept = s_axis_seg.tvalid & s_tready_q & (ena != '0);

    // Packet framing FSM: decide emit/discard and the tlast/tuser the emitted beat carries.
    always_comb begin
        state_d   = state_q;
        beat_emit = 1'b0;
        emit_last = beat_last;
        emit_user = 1'b0;
        if (beat_accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (sop[0]) begin
                        beat_emit = 1'b1;
                        if (beat_last) begin
                            emit_user = beat_err | viol;
                        end else if (viol) begin
                            emit_last = 1'b1;
                            emit_user = 1'b1;
                            state_d   = ST_DROP;
                        end else begin
                            state_d   = ST_IN_PKT;
                        end
                    end else if (!beat_last) begin
                        state_d = ST_DROP;
                    end
                end
                ST_IN_PKT: begin
                    beat_emit = 1'b1;
                    if (sop[0]) begin
                        // Previous packet truncated here; the new packet cannot be kept.
                        emit_last = 1'b1;
                        emit_user = 1'b1;
                        state_d   = beat_last ? ST_IDLE : ST_DROP;
                    end else if (beat_last) begin
                        emit_user = beat_err | viol;
                        state_d   = ST_IDLE;
                    end else if (viol) begin
                        emit_last = 1'b1;
                        emit_user = 1'b1;
                        state_d   = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (beat_last) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Framing state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    assign in_beat = '{data: s_axis_seg.tdata, keep: beat_keep, last: emit_last, user: emit_user};

    // Skid buffer steering: input lands in output or temp; temp refills output when drained.
    always_comb begin
        out_valid_d       = out_valid_q;
        tmp_valid_d       = tmp_valid_q;
        load_out_from_in  = 1'b0;
        load_tmp_from_in  = 1'b0;
        load_out_from_tmp = 1'b0;
        s_tready_d = m_axis.tready | (!tmp_valid_q & (!out_valid_q | !beat_emit));
        if (s_tready_q) begin
            if (m_axis.tready || !out_valid_q) begin
                out_valid_d      = beat_emit;
                load_out_from_in = 1'b1;
            end else begin
                tmp_valid_d      = beat_emit;
                load_tmp_from_in = 1'b1;
            end
        end else if (m_axis.tready) begin
            out_valid_d       = tmp_valid_q;
            tmp_valid_d       = 1'b0;
            load_out_from_tmp = 1'b1;
        end
    end

    // Skid buffer control flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            tmp_valid_q <= 1'b0;
            s_tready_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            tmp_valid_q <= tmp_valid_d;
            s_tready_q  <= s_tready_d;
        end
    end

    // Skid buffer payload registers.
    // NOTE: payload is qualified by the valid flags, so it carries no reset and stays plain flops.
    always_ff @(posedge clk) begin
        if (load_out_from_in)       out_q <= in_beat;
        else if (load_out_from_tmp) out_q <= tmp_q;
        if (load_tmp_from_in)       tmp_q <= in_beat;
    end

    assign s_axis_seg.tready = s_tready_q;
    assign m_axis.tvalid     = out_valid_q;
    assign m_axis.tdata      = out_q.data;
    assign m_axis.tkeep      = out_q.keep;
    assign m_axis.tlast      = out_q.last;
    assign m_axis.tuser      = out_q.user;

`ifdef AXIS_SEG_STATS_EN
    logic [COUNTER_WIDTH-1:0] pkt_cnt_q, err_cnt_q, drop_cnt_q;
    logic                     out_done, drop_beat;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    assign out_done  = out_valid_q & m_axis.tready & out_q.last;
    assign drop_beat = beat_accept & ~beat_emit;

    // Saturating packet, error-packet and dropped-beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (out_done && !out_q.user && (pkt_cnt_q != '1)) pkt_cnt_q  <= pkt_cnt_q + CNT_ONE;
            if (out_done &&  out_q.user && (err_cnt_q != '1)) err_cnt_q  <= err_cnt_q + CNT_ONE;
            if (drop_beat && (drop_cnt_q != '1))              drop_cnt_q <= drop_cnt_q + CNT_ONE;
        end
    end

    assign stat_pkt_count  = pkt_cnt_q;
    assign stat_err_count  = err_cnt_q;
    assign stat_drop_count = drop_cnt_q;
`else
    assign stat_pkt_count  = '0;
    assign stat_err_count  = '0;
    assign stat_drop_count = '0;
`endif

endmodule

// File: tb/tb_axi_seg_2_axis_simple.sv
// Self-checking bench for axi_seg_2_axis_simple: expected output beats are queued when
// stimulus is driven and compared as the DUT hands them off downstream.
module tb_axi_seg_2_axis_simple;
    localparam int COUNTER_WIDTH = 32;
`ifdef AXIS_SEG_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    typedef struct {
        logic [1023:0] data;
        logic [127:0]  keep;
        logic          last;
        logic          user;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [COUNTER_WIDTH-1:0] stat_pkt_count, stat_err_count, stat_drop_count;

    int   checks   = 0;
    int   failures = 0;
    int   bp_mode  = 0;
    exp_t exp_q[$];

    axi_seg_2_axis_simple_seg_if  s_if ();
    axi_seg_2_axis_simple_axis_if m_if ();

    axi_seg_2_axis_simple dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_seg      (s_if),
        .m_axis          (m_if),
        .stat_pkt_count  (stat_pkt_count),
        .stat_err_count  (stat_err_count),
        .stat_drop_count (stat_drop_count)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_stats(input int pkt, input int err, input int drop);
        check("stat_pkt",  stat_pkt_count,  STATS_EN ? pkt  : 0);
        check("stat_err",  stat_err_count,  STATS_EN ? err  : 0);
        check("stat_drop", stat_drop_count, STATS_EN ? drop : 0);
    endtask

    function automatic logic [1023:0] rnd_data();
        logic [1023:0] d;
        for (int k = 0; k < 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic push_exp(input logic [1023:0] data, input logic [127:0] keep,
                            input logic last, input logic user);
        exp_t e;
        e.data = data; e.keep = keep; e.last = last; e.user = user;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_beat(input logic [1023:0] data, input logic [7:0] ena, input logic [7:0] sop,
                             input logic [7:0] eop, input logic [7:0] err, input logic [31:0] mty);
        int guard;
        // NOTE: bench drives inputs with blocking assignments at the falling edge, clear of the sampling edge.
        s_if.tdata     = data;
        s_if.tuser_ena = ena;
        s_if.tuser_sop = sop;
        s_if.tuser_eop = eop;
        s_if.tuser_err = err;
        s_if.tuser_mty = mty;
        s_if.tvalid    = 1'b1;
        guard = 0;
        while (!s_if.tready) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                check("accept_timeout", 0, 1);
                s_if.tvalid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain_sb_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Downstream ready pattern: 0 always ready, 1 toggling, 2 stalled, 3 random.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(negedge clk);
            case (bp_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = ~m_if.tready;
                2:       m_if.tready = 1'b0;
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: samples just before each rising edge and pops the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    for (int k = 0; k < 4; k++) check("tdata", m_if.tdata[k*256 +: 256], e.data[k*256 +: 256]);
                    check("tkeep", m_if.tkeep, e.keep);
                    check("tlast", m_if.tlast, e.last);
                    check("tuser", m_if.tuser, e.user);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] d;
        time t0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser_ena = '0; s_if.tuser_sop = '0;
        s_if.tuser_eop = '0; s_if.tuser_err = '0; s_if.tuser_mty = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_s_tready", s_if.tready, 0);
        check_stats(0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("tready_after_rst", s_if.tready, 1);

        // Single-beat packet, 60 bytes
        d = rnd_data(); push_exp(d, 128'h0FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        send_beat(d, 8'h0F, 8'h01, 8'h08, 8'h00, 32'h0000_4000);
        drain(); check_stats(1, 0, 0);

        // Three-beat packet under toggling backpressure
        bp_mode = 1;
        d = rnd_data(); push_exp(d, '1, 1'b0, 1'b0); send_beat(d, 8'hFF, 8'h01, 8'h00, 8'h00, 32'h0);
        d = rnd_data(); push_exp(d, '1, 1'b0, 1'b0); send_beat(d, 8'hFF, 8'h00, 8'h00, 8'h00, 32'h0);
        d = rnd_data(); push_exp(d, 128'hFFFF_FFFF, 1'b1, 1'b0); send_beat(d, 8'h03, 8'h00, 8'h02, 8'h00, 32'h0);
        drain(); bp_mode = 0; check_stats(2, 0, 0);

        // Beats without sop in IDLE are dropped, then a good packet passes
        send_beat(rnd_data(), 8'hFF, 8'h00, 8'h00, 8'h00, 32'h0);
        send_beat(rnd_data(), 8'hFF, 8'h00, 8'h80, 8'h00, 32'h0);
        drain(); check_stats(2, 0, 2);
        d = rnd_data(); push_exp(d, '1, 1'b1, 1'b0); send_beat(d, 8'hFF, 8'h01, 8'h80, 8'h00, 32'h0);
        drain(); check_stats(3, 0, 2);

        // sop while in a packet truncates it; FSM back in IDLE afterwards
        d = rnd_data(); push_exp(d, '1, 1'b0, 1'b0); send_beat(d, 8'hFF, 8'h01, 8'h00, 8'h00, 32'h0);
        d = rnd_data(); push_exp(d, '1, 1'b1, 1'b1); send_beat(d, 8'hFF, 8'h01, 8'h80, 8'h00, 32'h0);
        d = rnd_data(); push_exp(d, '1, 1'b1, 1'b0); send_beat(d, 8'hFF, 8'h01, 8'h80, 8'h00, 32'h0);
        drain(); check_stats(4, 1, 2);

        // MAC error on a 48-byte packet
        d = rnd_data(); push_exp(d, 128'hFFFF_FFFF_FFFF, 1'b1, 1'b1);
        send_beat(d, 8'h07, 8'h01, 8'h04, 8'h04, 32'h0);
        drain(); check_stats(4, 2, 2);

        // Non-contiguous enables with eop: emitted, flagged bad
        d = rnd_data(); push_exp(d, {80'h0, 16'hFFFF, 16'h0000, 16'hFFFF}, 1'b1, 1'b1);
        send_beat(d, 8'h05, 8'h01, 8'h04, 8'h00, 32'h0);
        drain(); check_stats(4, 3, 2);

        // Short beat without eop: forced end, rest dropped; empty beat ignored
        d = rnd_data(); push_exp(d, 128'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        send_beat(d, 8'h0F, 8'h01, 8'h00, 8'h00, 32'h0);
        send_beat(rnd_data(), 8'hFF, 8'h00, 8'h80, 8'h00, 32'h0);
        send_beat(rnd_data(), 8'h00, 8'h01, 8'h00, 8'h00, 32'h0);
        d = rnd_data(); push_exp(d, '1, 1'b1, 1'b0); send_beat(d, 8'hFF, 8'h01, 8'h80, 8'h00, 32'h0);
        drain(); check_stats(5, 4, 3);

        // Back-to-back packets under random backpressure
        bp_mode = 3;
        for (int i = 0; i < 6; i++) begin
            d = rnd_data(); push_exp(d, '1, 1'b1, 1'b0); send_beat(d, 8'hFF, 8'h01, 8'h80, 8'h00, 32'h0);
        end
        drain(); bp_mode = 0; repeat (2) @(negedge clk); check_stats(11, 4, 3);

        // Full throughput: four beats accepted in four cycles
        t0 = $time;
        d = rnd_data(); push_exp(d, '1, 1'b0, 1'b0); send_beat(d, 8'hFF, 8'h01, 8'h00, 8'h00, 32'h0);
        for (int i = 0; i < 2; i++) begin
            d = rnd_data(); push_exp(d, '1, 1'b0, 1'b0); send_beat(d, 8'hFF, 8'h00, 8'h00, 8'h00, 32'h0);
        end
        d = rnd_data(); push_exp(d, '1, 1'b1, 1'b0); send_beat(d, 8'hFF, 8'h00, 8'h80, 8'h00, 32'h0);
        check("throughput_cycles", ($time - t0) / 10, 4);
        drain(); check_stats(12, 4, 3);

        // Reset mid-packet while the output holds a beat
        bp_mode = 2;
        repeat (2) @(negedge clk);
        d = rnd_data(); push_exp(d, '1, 1'b0, 1'b0); send_beat(d, 8'hFF, 8'h01, 8'h00, 8'h00, 32'h0);
        check("mid_pkt_tvalid", m_if.tvalid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_tvalid", m_if.tvalid, 0);
        check("rst_async_tready", s_if.tready, 0);
        check_stats(0, 0, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bp_mode = 0;
        @(negedge clk);
        check("tready_after_rst2", s_if.tready, 1);
        d = rnd_data(); push_exp(d, '1, 1'b1, 1'b0); send_beat(d, 8'hFF, 8'h01, 8'h80, 8'h00, 32'h0);
        drain(); check_stats(1, 0, 0);

        check("final_sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
